raptor64_operand_sequencer: RTL and testbench

- Register-specifier stage between instruction fetch and register-file read.
- Forms the three read-port addresses dRa, dRb and dRc as {context, register} from the fetched instruction.
- Generalises the context width and adds a multi-cycle walker for LM/SM. The walker issues one dRb per set mask bit and stalls fetch until the mask is exhausted.
- Keeps the RET, SETLO and SETHI overrides and the EXEC override from the execute stage.

---
 rtl/raptor64_operand_sequencer_if.sv | 31 +++
 rtl/raptor64_operand_sequencer.sv | 178 +++++++++++++++++
 tb/tb_raptor64_operand_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/raptor64_operand_sequencer_if.sv
// Bus between the fetch/execute stages and the register-specifier stage.
// master: drives advances, instruction words, operand b and context;
//         receives the three read-port addresses and the LM/SM walk status.
// slave : the operand sequencer itself.
interface raptor64_operand_sequencer_if #(
    parameter int CTXW = 4
);
    logic              advanceI;
    logic              advanceR;
    logic              advanceX;
    logic [63:0]       b;
    logic [CTXW-1:0]   AXC;
    logic [41:0]       insn;
    logic [41:0]       xIR;
    logic [CTXW+4:0]   dRa;
    logic [CTXW+4:0]   dRb;
    logic [CTXW+4:0]   dRc;
    logic              mstall;
    logic              mlast;
    logic [4:0]        moff;

    modport master (
        output advanceI, advanceR, advanceX, b, AXC, insn, xIR,
        input  dRa, dRb, dRc, mstall, mlast, moff
    );

    modport slave (
        input  advanceI, advanceR, advanceX, b, AXC, insn, xIR,
        output dRa, dRb, dRc, mstall, mlast, moff
    );
endinterface

// File: rtl/raptor64_operand_sequencer.sv
// Register-specifier stage: forms read-port addresses {context, register}
// from the fetched instruction, walks LM/SM register masks one register per
// cycle (holding fetch via mstall), and honours the execute-stage EXEC
// override.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - slave side of raptor64_operand_sequencer_if (advances, insn, xIR,
//          b, AXC in; dRa/dRb/dRc, mstall, mlast, moff out, all registered)
module raptor64_operand_sequencer #(
    parameter int CTXW     = 4,
    parameter int MULTI_EN = 1
) (
    input  logic clk,
    input  logic rst,
    raptor64_operand_sequencer_if.slave bus
);
    localparam int AW = CTXW + 5;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WALK = 1'b1;

    localparam logic [6:0] OP_R     = 7'd1;
    localparam logic [6:0] OP_RET   = 7'd56;
    localparam logic [6:0] OP_LM    = 7'd61;
    localparam logic [6:0] OP_SM    = 7'd62;
    // SETLO/SETHI use a 5-bit major opcode; insn[36:32] carries the target.
    localparam logic [4:0] OP5_SETLO = 5'b11100;
    localparam logic [4:0] OP5_SETHI = 5'b11101;
    localparam logic [6:0] FN_EXEC   = 7'd10;

    // Index (0..30) of the lowest set bit; 0 when the mask is empty.
    function automatic logic [4:0] lowestIdx(input logic [30:0] m);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 30; i >= 0; i--) begin
            if (m[i]) begin
                idx = 5'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [0:0]      state_r,  nState_s;
    logic [30:0]     mask_r,   nMask_s;
    logic [CTXW-1:0] ctx_r,    nCtx_s;
    logic [AW-1:0]   dRa_r,    nDra_s;
    logic [AW-1:0]   dRb_r,    nDrb_s;
    logic [AW-1:0]   dRc_r,    nDrc_s;
    logic            mlast_r,  nMlast_s;
    logic [4:0]      moff_r,   nMoff_s;

    logic [6:0]      opcode_s;
    logic            isExec_s;
    logic [30:0]     insnMask_s;
    logic [4:0]      insnIdx_s;
    logic [4:0]      walkIdx_s;
    logic [30:0]     walkRest_s;
    logic            singleBit_s;

    // Next-state / next-output computation with EXEC > WALK > decode > clear.
    always_comb begin
        opcode_s    = bus.insn[41:35];
        isExec_s    = bus.advanceX && (bus.xIR[41:35] == OP_R) && (bus.xIR[6:0] == FN_EXEC);
        insnMask_s  = bus.insn[30:0];
        insnIdx_s   = lowestIdx(insnMask_s);
        walkIdx_s   = lowestIdx(mask_r);
        walkRest_s  = mask_r & ~(31'd1 << walkIdx_s);
        singleBit_s = ((insnMask_s & (insnMask_s - 31'd1)) == 31'd0);

        nState_s = state_r;
        nMask_s  = mask_r;
        nCtx_s   = ctx_r;
        nDra_s   = dRa_r;
        nDrb_s   = dRb_r;
        nDrc_s   = dRc_r;
        nMlast_s = mlast_r;
        nMoff_s  = moff_r;

        if (isExec_s) begin
            nDra_s   = {bus.AXC, bus.b[34:30]};
            nDrb_s   = {bus.AXC, bus.b[29:25]};
            nDrc_s   = {bus.AXC, bus.b[24:20]};
            nState_s = IDLE;
            nMask_s  = 31'd0;
            nMlast_s = 1'b0;
            nMoff_s  = 5'd0;
        end else if (state_r == WALK) begin
            if (bus.advanceR) begin
                nDrb_s  = {ctx_r, walkIdx_s + 5'd1};
                nMask_s = walkRest_s;
                nMoff_s = (moff_r == 5'd31) ? 5'd31 : moff_r + 5'd1;
                if (walkRest_s == 31'd0) begin
                    nMlast_s = 1'b1;
                    nState_s = IDLE;
                end else begin
                    nMlast_s = 1'b0;
                end
            end else begin
                nState_s = state_r;
            end
        end else if (bus.advanceI) begin
            nDra_s   = {bus.AXC, bus.insn[34:30]};
            nDrb_s   = {bus.AXC, bus.insn[29:25]};
            nDrc_s   = {bus.AXC, bus.insn[24:20]};
            nMlast_s = 1'b0;
            nMoff_s  = 5'd0;
            case (opcode_s)
                OP_RET: begin
                    nDra_s = {bus.AXC, 5'd30};
                    nDrb_s = {bus.AXC, 5'd31};
                end
                OP_LM, OP_SM: begin
                    nDra_s   = {bus.AXC, 1'b1, bus.insn[34:31]};
                    nMlast_s = 1'b1;
                    if (insnMask_s == 31'd0) begin
                        nDrb_s = {bus.AXC, 5'd0};
                    end else if (singleBit_s || (MULTI_EN == 0)) begin
                        nDrb_s = {bus.AXC, insnIdx_s + 5'd1};
                    end else begin
                        // More than one register: issue the first now, walk the rest.
                        nDrb_s   = {bus.AXC, insnIdx_s + 5'd1};
                        nMask_s  = insnMask_s & ~(31'd1 << insnIdx_s);
                        nCtx_s   = bus.AXC;
                        nMlast_s = 1'b0;
                        nState_s = WALK;
                    end
                end
                default: begin
                    if ((opcode_s[6:2] == OP5_SETLO) || (opcode_s[6:2] == OP5_SETHI)) begin
                        nDra_s = {bus.AXC, bus.insn[36:32]};
                    end else begin
                        nDra_s = {bus.AXC, bus.insn[34:30]};
                    end
                end
            endcase
        end else if (bus.advanceR) begin
            nDra_s   = {AW{1'b0}};
            nDrb_s   = {AW{1'b0}};
            nDrc_s   = {AW{1'b0}};
            nMlast_s = 1'b0;
        end else begin
            nState_s = state_r;
        end
    end

    // State and output registers; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            mask_r  <= 31'd0;
            ctx_r   <= {CTXW{1'b0}};
            dRa_r   <= {AW{1'b0}};
            dRb_r   <= {AW{1'b0}};
            dRc_r   <= {AW{1'b0}};
            mlast_r <= 1'b0;
            moff_r  <= 5'd0;
        end else begin
            state_r <= nState_s;
            mask_r  <= nMask_s;
            ctx_r   <= nCtx_s;
            dRa_r   <= nDra_s;
            dRb_r   <= nDrb_s;
            dRc_r   <= nDrc_s;
            mlast_r <= nMlast_s;
            moff_r  <= nMoff_s;
        end
    end

    assign bus.dRa    = dRa_r;
    assign bus.dRb    = dRb_r;
    assign bus.dRc    = dRc_r;
    assign bus.mstall = (state_r == WALK);
    assign bus.mlast  = mlast_r;
    assign bus.moff   = moff_r;
endmodule

// File: tb/tb_raptor64_operand_sequencer.sv
module tb_raptor64_operand_sequencer;
    localparam logic [6:0] OP_GEN  = 7'd0;
    localparam logic [6:0] OP_R    = 7'd1;
    localparam logic [6:0] OP_RET  = 7'd56;
    localparam logic [6:0] OP_LM   = 7'd61;
    localparam logic [6:0] OP_SETLO = 7'b1110000;
    localparam logic [6:0] FN_EXEC = 7'd10;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    raptor64_operand_sequencer_if #(.CTXW(4)) bus0 ();
    raptor64_operand_sequencer_if #(.CTXW(4)) bus1 ();

    raptor64_operand_sequencer #(.CTXW(4), .MULTI_EN(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    raptor64_operand_sequencer #(.CTXW(4), .MULTI_EN(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [41:0] mkInsn(input logic [6:0] op, input logic [4:0] ra,
                                           input logic [4:0] rb, input logic [4:0] rc);
        return {op, ra, rb, rc, 20'd0};
    endfunction

    function automatic logic [41:0] mkLm(input logic [3:0] base, input logic [30:0] m);
        return {OP_LM, base, m};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.advanceI = 1'b0;
        bus0.advanceR = 1'b0;
        bus0.advanceX = 1'b0;
        bus0.b        = 64'd0;
        bus0.insn     = 42'd0;
        bus0.xIR      = 42'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus0.AXC = 4'd5;
        bus0.advanceI = 1'b1;
        bus0.insn = mkInsn(OP_GEN, 5'd7, 5'd9, 5'd11);
        step();
        step();
        total++; if (bus0.dRa !== 9'h0) begin bad++; $display("FAIL reset_dRa got=%h exp=0", bus0.dRa); end
        total++; if (bus0.dRb !== 9'h0) begin bad++; $display("FAIL reset_dRb got=%h exp=0", bus0.dRb); end
        total++; if (bus0.dRc !== 9'h0) begin bad++; $display("FAIL reset_dRc got=%h exp=0", bus0.dRc); end
        total++; if (bus0.mstall !== 1'b0) begin bad++; $display("FAIL reset_mstall got=%b exp=0", bus0.mstall); end
        rst = 1'b1;
        idle0();
        step();
    endtask

    task automatic test_decode();
        bus0.AXC = 4'd3;
        bus0.advanceI = 1'b1;
        bus0.insn = mkInsn(OP_GEN, 5'd7, 5'd9, 5'd11);
        step();
        total++; if (bus0.dRa !== 9'h067) begin bad++; $display("FAIL dec_dRa got=%h exp=067", bus0.dRa); end
        total++; if (bus0.dRb !== 9'h069) begin bad++; $display("FAIL dec_dRb got=%h exp=069", bus0.dRb); end
        total++; if (bus0.dRc !== 9'h06B) begin bad++; $display("FAIL dec_dRc got=%h exp=06B", bus0.dRc); end
        bus0.insn = mkInsn(OP_RET, 5'd1, 5'd2, 5'd3);
        step();
        total++; if (bus0.dRa !== 9'h07E) begin bad++; $display("FAIL ret_dRa got=%h exp=07E", bus0.dRa); end
        total++; if (bus0.dRb !== 9'h07F) begin bad++; $display("FAIL ret_dRb got=%h exp=07F", bus0.dRb); end
        // SETLO: target register from insn[36:32] = 13
        bus0.insn = {OP_SETLO[6:2], 5'd13, 32'd0};
        step();
        total++; if (bus0.dRa !== 9'h06D) begin bad++; $display("FAIL setlo_dRa got=%h exp=06D", bus0.dRa); end
        bus0.advanceI = 1'b0;
        bus0.advanceR = 1'b1;
        step();
        total++; if (bus0.dRa !== 9'h0 || bus0.dRb !== 9'h0 || bus0.dRc !== 9'h0) begin
            bad++; $display("FAIL clear_regs got=%h/%h/%h exp=0", bus0.dRa, bus0.dRb, bus0.dRc);
        end
        idle0();
        step();
    endtask

    task automatic test_lm_walk();
        bus0.AXC = 4'd2;
        bus0.advanceI = 1'b1;
        bus0.advanceR = 1'b1;
        bus0.insn = mkLm(4'd3, 31'h15);
        step();
        total++; if (bus0.dRa !== 9'h053) begin bad++; $display("FAIL lm_dRa got=%h exp=053", bus0.dRa); end
        total++; if (bus0.dRb !== 9'h041 || bus0.moff !== 5'd0) begin bad++; $display("FAIL lm_step0 got=%h/%0d exp=041/0", bus0.dRb, bus0.moff); end
        total++; if (bus0.mstall !== 1'b1 || bus0.mlast !== 1'b0) begin bad++; $display("FAIL lm_stall0 got=%b/%b exp=1/0", bus0.mstall, bus0.mlast); end
        // Context change and new insn must not affect the walk.
        bus0.AXC = 4'd7;
        bus0.insn = mkInsn(OP_GEN, 5'd1, 5'd1, 5'd1);
        step();
        total++; if (bus0.dRb !== 9'h043 || bus0.moff !== 5'd1) begin bad++; $display("FAIL lm_step1 got=%h/%0d exp=043/1", bus0.dRb, bus0.moff); end
        total++; if (bus0.mstall !== 1'b1) begin bad++; $display("FAIL lm_stall1 got=%b exp=1", bus0.mstall); end
        bus0.advanceR = 1'b0;
        step();
        step();
        total++; if (bus0.dRb !== 9'h043 || bus0.moff !== 5'd1 || bus0.mstall !== 1'b1 || bus0.dRa !== 9'h053) begin
            bad++; $display("FAIL lm_freeze got=%h/%0d/%b exp=043/1/1", bus0.dRb, bus0.moff, bus0.mstall);
        end
        bus0.advanceR = 1'b1;
        step();
        total++; if (bus0.dRb !== 9'h045 || bus0.moff !== 5'd2) begin bad++; $display("FAIL lm_step2 got=%h/%0d exp=045/2", bus0.dRb, bus0.moff); end
        total++; if (bus0.mlast !== 1'b1 || bus0.mstall !== 1'b0) begin bad++; $display("FAIL lm_last got=%b/%b exp=1/0", bus0.mlast, bus0.mstall); end
        total++; if (bus0.dRa !== 9'h053) begin bad++; $display("FAIL lm_dRa_hold got=%h exp=053", bus0.dRa); end
        idle0();
        step();
    endtask

    task automatic test_boundaries();
        bus0.AXC = 4'd2;
        bus0.advanceI = 1'b1;
        bus0.insn = mkLm(4'd0, 31'h0);
        step();
        total++; if (bus0.dRb !== 9'h040 || bus0.mlast !== 1'b1 || bus0.mstall !== 1'b0) begin
            bad++; $display("FAIL mask0 got=%h/%b/%b exp=040/1/0", bus0.dRb, bus0.mlast, bus0.mstall);
        end
        bus0.insn = mkLm(4'd0, 31'h40000000);
        step();
        total++; if (bus0.dRb !== 9'h05F || bus0.mlast !== 1'b1 || bus0.mstall !== 1'b0) begin
            bad++; $display("FAIL mask_top got=%h/%b/%b exp=05F/1/0", bus0.dRb, bus0.mlast, bus0.mstall);
        end
        bus0.advanceR = 1'b1;
        bus0.insn = mkLm(4'd0, 31'h7FFFFFFF);
        step();
        bus0.advanceI = 1'b0;
        total++; if (bus0.dRb !== 9'h041 || bus0.mstall !== 1'b1) begin bad++; $display("FAIL full_first got=%h/%b exp=041/1", bus0.dRb, bus0.mstall); end
        for (int i = 2; i <= 31; i++) begin
            step();
            total++; if (bus0.dRb !== 9'(9'h040 + i) || bus0.moff !== 5'(i - 1)) begin
                bad++; $display("FAIL full_step got=%h/%0d exp=%h/%0d", bus0.dRb, bus0.moff, 9'(9'h040 + i), i - 1);
            end
        end
        total++; if (bus0.moff !== 5'd30 || bus0.mlast !== 1'b1 || bus0.mstall !== 1'b0) begin
            bad++; $display("FAIL full_end got=%0d/%b/%b exp=30/1/0", bus0.moff, bus0.mlast, bus0.mstall);
        end
        idle0();
        step();
    endtask

    task automatic test_single_mode();
        bus1.AXC = 4'd2;
        bus1.advanceI = 1'b1;
        bus1.advanceR = 1'b1;
        bus1.insn = mkLm(4'd0, 31'h0C);
        step();
        total++; if (bus1.dRb !== 9'h043 || bus1.mlast !== 1'b1 || bus1.mstall !== 1'b0) begin
            bad++; $display("FAIL single got=%h/%b/%b exp=043/1/0", bus1.dRb, bus1.mlast, bus1.mstall);
        end
        bus1.advanceI = 1'b0;
        bus1.advanceR = 1'b0;
        step();
        total++; if (bus1.mstall !== 1'b0 || bus1.dRb !== 9'h043) begin bad++; $display("FAIL single_nostall got=%b/%h exp=0/043", bus1.mstall, bus1.dRb); end
    endtask

    task automatic test_exec();
        bus0.AXC = 4'd1;
        bus0.advanceI = 1'b1;
        bus0.advanceR = 1'b1;
        bus0.insn = mkLm(4'd0, 31'h15);
        step();
        total++; if (bus0.mstall !== 1'b1) begin bad++; $display("FAIL exec_pre got=%b exp=1", bus0.mstall); end
        bus0.advanceX = 1'b1;
        bus0.xIR = {OP_R, 28'd0, FN_EXEC};
        bus0.b = {29'd0, 5'd4, 5'd5, 5'd6, 20'd0};
        step();
        total++; if (bus0.dRa !== 9'h024 || bus0.dRb !== 9'h025 || bus0.dRc !== 9'h026) begin
            bad++; $display("FAIL exec_walk got=%h/%h/%h exp=024/025/026", bus0.dRa, bus0.dRb, bus0.dRc);
        end
        total++; if (bus0.mstall !== 1'b0 || bus0.mlast !== 1'b0 || bus0.moff !== 5'd0) begin
            bad++; $display("FAIL exec_state got=%b/%b/%0d exp=0/0/0", bus0.mstall, bus0.mlast, bus0.moff);
        end
        bus0.insn = mkInsn(OP_GEN, 5'd7, 5'd9, 5'd11);
        bus0.b = {29'd0, 5'd8, 5'd9, 5'd10, 20'd0};
        step();
        total++; if (bus0.dRa !== 9'h028 || bus0.dRb !== 9'h029 || bus0.dRc !== 9'h02A) begin
            bad++; $display("FAIL exec_vs_decode got=%h/%h/%h exp=028/029/02A", bus0.dRa, bus0.dRb, bus0.dRc);
        end
        idle0();
        step();
    endtask

    task automatic test_reset_midwalk();
        bus0.AXC = 4'd2;
        bus0.advanceI = 1'b1;
        bus0.advanceR = 1'b1;
        bus0.insn = mkLm(4'd0, 31'h15);
        step();
        bus0.advanceI = 1'b0;
        bus0.advanceR = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++; if (bus0.mstall !== 1'b0 || bus0.dRb !== 9'h0 || bus0.dRa !== 9'h0 || bus0.moff !== 5'd0) begin
            bad++; $display("FAIL rst_mid got=%b/%h/%h/%0d exp=0/0/0/0", bus0.mstall, bus0.dRb, bus0.dRa, bus0.moff);
        end
        step();
        rst = 1'b1;
        bus0.advanceI = 1'b1;
        bus0.advanceR = 1'b1;
        bus0.insn = mkLm(4'd0, 31'h3);
        step();
        bus0.advanceI = 1'b0;
        total++; if (bus0.dRb !== 9'h041 || bus0.mstall !== 1'b1) begin bad++; $display("FAIL rst_new0 got=%h/%b exp=041/1", bus0.dRb, bus0.mstall); end
        step();
        total++; if (bus0.dRb !== 9'h042 || bus0.mlast !== 1'b1 || bus0.moff !== 5'd1 || bus0.mstall !== 1'b0) begin
            bad++; $display("FAIL rst_new1 got=%h/%b/%0d/%b exp=042/1/1/0", bus0.dRb, bus0.mlast, bus0.moff, bus0.mstall);
        end
        idle0();
        step();
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        idle0();
        bus0.AXC = 4'd0;
        bus1.advanceI = 1'b0;
        bus1.advanceR = 1'b0;
        bus1.advanceX = 1'b0;
        bus1.b = 64'd0;
        bus1.AXC = 4'd0;
        bus1.insn = 42'd0;
        bus1.xIR = 42'd0;
        #3;
        test_reset();
        test_decode();
        test_lm_walk();
        test_boundaries();
        test_single_mode();
        test_exec();
        test_reset_midwalk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
